// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  // Widest register address the tracking entry can hold; ADDR_W must not exceed it.
  localparam int RD_MAX_W = 8;

  // Forward-select encoding for "read the register file".
  localparam int FWD_RF = 0;

  // Instruction word injected into EX as a bubble.
  localparam logic [15:0] NOP_INSN = 16'h7000;

  // One in-flight instruction behind decode.
  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                wen;
    logic                is_load;
  } entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_src_match.sv
// Per-source hazard detection: picks the youngest in-flight writer of one
// source register and flags a load-use hazard when its data is not ready yet.
module hazard_src_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int ZERO_REG = 1,
  parameter int SEL_W    = 2
) (
  input  logic [ADDR_W-1:0] src,
  input  logic              src_used,
  input  logic              id_valid,
  input  entry_t [DEPTH-1:0] entries,
  output logic [SEL_W-1:0]  sel,
  output logic              load_use
);

  logic match_en;
  logic sel_load;

  // Scan oldest to youngest so the youngest matching writer (lowest k) wins.
  always_comb begin
    sel      = SEL_W'(FWD_RF);
    sel_load = 1'b0;
    match_en = src_used && id_valid && !((ZERO_REG == 1) && (src == '0));
    for (int k = DEPTH; k >= 1; k--) begin
      if (match_en && entries[k-1].valid && entries[k-1].wen &&
          (entries[k-1].rd == RD_MAX_W'(src))) begin
        sel      = SEL_W'(k);
        sel_load = entries[k-1].is_load;
      end
    end
    load_use = sel_load && (int'(sel) < LOAD_LAT);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight writers behind decode, chooses
// forwarding sources, stalls on load-use and squashes on taken branches.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int ZERO_REG = 1,
  parameter int STAT_W   = 16,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 id_valid,
  input  logic [ADDR_W-1:0]    id_rs,
  input  logic [ADDR_W-1:0]    id_rt,
  input  logic                 id_rs_used,
  input  logic                 id_rt_used,
  input  logic [ADDR_W-1:0]    id_rd,
  input  logic                 id_wen,
  input  logic                 id_is_load,
  input  logic                 br_taken,
  input  logic                 ext_stall,
  output logic                 stall_if_id,
  output logic                 bubble_ex,
  output logic                 flush,
  output logic [SEL_W-1:0]     fwd_rs_sel,
  output logic [SEL_W-1:0]     fwd_rt_sel,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic [STAT_W-1:0]    stall_cnt
);

  // Index 0 holds stage 1 (EX), index DEPTH-1 holds stage DEPTH (WB).
  entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [STAT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [SEL_W-1:0] rs_sel, rt_sel;
  logic             rs_load_use, rt_load_use;

  hazard_src_match #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .LOAD_LAT(LOAD_LAT),
    .ZERO_REG(ZERO_REG),
    .SEL_W   (SEL_W)
  ) u_match_rs (
    .src     (id_rs),
    .src_used(id_rs_used),
    .id_valid(id_valid),
    .entries (entries_q),
    .sel     (rs_sel),
    .load_use(rs_load_use)
  );

  hazard_src_match #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .LOAD_LAT(LOAD_LAT),
    .ZERO_REG(ZERO_REG),
    .SEL_W   (SEL_W)
  ) u_match_rt (
    .src     (id_rt),
    .src_used(id_rt_used),
    .id_valid(id_valid),
    .entries (entries_q),
    .sel     (rt_sel),
    .load_use(rt_load_use)
  );

  // Control outputs; a taken branch beats the stall, a frozen pipe suppresses both,
  // and everything reads 0 while reset is held.
  always_comb begin
    flush       = Rst && br_taken && !ext_stall;
    stall_if_id = Rst && (rs_load_use || rt_load_use) && !ext_stall && !br_taken;
    bubble_ex   = stall_if_id;
    fwd_rs_sel  = (Rst && !stall_if_id) ? rs_sel : SEL_W'(FWD_RF);
    fwd_rt_sel  = (Rst && !stall_if_id) ? rt_sel : SEL_W'(FWD_RF);
    stall_cnt   = stall_cnt_q;
  end

  // One bit per register with a pending write anywhere in the tracked stages.
  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entries_q[k].valid && entries_q[k].wen) begin
        busy_mask[entries_q[k].rd[ADDR_W-1:0]] = 1'b1;
      end
    end
  end

  // Advance the tracking pipe unless memory freezes it; stalls and flushes insert a bubble.
  always_comb begin
    entries_d   = entries_q;
    stall_cnt_d = stall_cnt_q;
    if (!ext_stall) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = '0;
      if (id_valid && !stall_if_id && !flush) begin
        entries_d[0].valid   = 1'b1;
        entries_d[0].rd      = RD_MAX_W'(id_rd);
        entries_d[0].wen     = id_wen;
        entries_d[0].is_load = id_is_load;
      end
      if (stall_if_id && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      entries_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with default parameters.
module tb_pipe_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        id_valid;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic        id_rs_used, id_rt_used, id_wen, id_is_load;
  logic        br_taken, ext_stall;
  logic        stall_if_id, bubble_ex, flush;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [15:0] busy_mask;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_rd      (id_rd),
    .id_wen     (id_wen),
    .id_is_load (id_is_load),
    .br_taken   (br_taken),
    .ext_stall  (ext_stall),
    .stall_if_id(stall_if_id),
    .bubble_ex  (bubble_ex),
    .flush      (flush),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .busy_mask  (busy_mask),
    .stall_cnt  (stall_cnt)
  );

  task automatic set_id(input logic v, input logic [3:0] rs, input logic rsu,
                        input logic [3:0] rt, input logic rtu, input logic [3:0] rd,
                        input logic wen, input logic ld);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_wen = wen; id_is_load = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    br_taken = 1'b0; ext_stall = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    set_id(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1);
    br_taken = 1'b1; ext_stall = 1'b0;
    step(); settle();
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush); end
    n_checks++; if (stall_if_id !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall_if_id); end
    n_checks++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL rst_busy: got %h want 0000", busy_mask); end
    n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
    n_checks++; if ({fwd_rs_sel, fwd_rt_sel, bubble_ex} !== 5'b0) begin n_fail++; $display("FAIL rst_fwd: got %b want 00000", {fwd_rs_sel, fwd_rt_sel, bubble_ex}); end
    idle();
    Rst = 1'b1;
    step();
    exp_cnt = 16'd0;
  endtask

  task automatic test_forward();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);  // ADD R3,R1,R2
    settle();
    n_checks++; if (stall_if_id !== 1'b0) begin n_fail++; $display("FAIL fw_nostall0: got %b want 0", stall_if_id); end
    step();
    set_id(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0);  // ADD R4,R3,R1
    settle();
    n_checks++; if (fwd_rs_sel !== 2'd1) begin n_fail++; $display("FAIL fw_rs_k1: got %0d want 1", fwd_rs_sel); end
    n_checks++; if (fwd_rt_sel !== 2'd0) begin n_fail++; $display("FAIL fw_rt_rf: got %0d want 0", fwd_rt_sel); end
    n_checks++; if (stall_if_id !== 1'b0) begin n_fail++; $display("FAIL fw_nostall1: got %b want 0", stall_if_id); end
    n_checks++; if (busy_mask !== 16'h0008) begin n_fail++; $display("FAIL fw_busy1: got %h want 0008", busy_mask); end
    step();
    set_id(1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 4'd9, 1'b1, 1'b0);  // ADD R9,R3,R2
    settle();
    n_checks++; if (fwd_rs_sel !== 2'd2) begin n_fail++; $display("FAIL fw_rs_k2: got %0d want 2", fwd_rs_sel); end
    n_checks++; if (busy_mask !== 16'h0018) begin n_fail++; $display("FAIL fw_busy2: got %h want 0018", busy_mask); end
    step();
    set_id(1'b1, 4'd4, 1'b1, 4'd3, 1'b1, 4'd10, 1'b1, 1'b0);  // reads R4 (k=2), R3 (k=3)
    settle();
    n_checks++; if (fwd_rs_sel !== 2'd2) begin n_fail++; $display("FAIL fw_rs_r4: got %0d want 2", fwd_rs_sel); end
    n_checks++; if (fwd_rt_sel !== 2'd3) begin n_fail++; $display("FAIL fw_rt_k3: got %0d want 3", fwd_rt_sel); end
    n_checks++; if (busy_mask !== 16'h0218) begin n_fail++; $display("FAIL fw_busy3: got %h want 0218", busy_mask); end
    step();
    // R10 writer was entered; R3 has now retired.
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    n_checks++; if (fwd_rs_sel !== 2'd0) begin n_fail++; $display("FAIL fw_retired: got %0d want 0", fwd_rs_sel); end
    n_checks++; if (busy_mask !== 16'h0610) begin n_fail++; $display("FAIL fw_busy4: got %h want 0610", busy_mask); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);  // LW R5
    step();
    set_id(1'b1, 4'd5, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1, 1'b0);  // SUB R6,R5,R2
    settle();
    n_checks++; if (stall_if_id !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall_if_id); end
    n_checks++; if (bubble_ex !== 1'b1) begin n_fail++; $display("FAIL lu_bubble: got %b want 1", bubble_ex); end
    n_checks++; if (fwd_rs_sel !== 2'd0) begin n_fail++; $display("FAIL lu_fwd_zero: got %0d want 0", fwd_rs_sel); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL lu_cnt0: got %0d want %0d", stall_cnt, exp_cnt); end
    step();
    exp_cnt++;
    settle();
    n_checks++; if (stall_if_id !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle: got %b want 0", stall_if_id); end
    n_checks++; if (fwd_rs_sel !== 2'd2) begin n_fail++; $display("FAIL lu_fwd_k2: got %0d want 2", fwd_rs_sel); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL lu_cnt1: got %0d want %0d", stall_cnt, exp_cnt); end
    step();
    drain();
  endtask

  task automatic test_flush();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);  // LW R5
    step();
    set_id(1'b1, 4'd5, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1, 1'b0);
    br_taken = 1'b1;
    settle();
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL fl_flush: got %b want 1", flush); end
    n_checks++; if (stall_if_id !== 1'b0) begin n_fail++; $display("FAIL fl_nostall: got %b want 0", stall_if_id); end
    n_checks++; if (bubble_ex !== 1'b0) begin n_fail++; $display("FAIL fl_nobubble: got %b want 0", bubble_ex); end
    step();
    idle();
    settle();
    n_checks++; if (busy_mask !== 16'h0020) begin n_fail++; $display("FAIL fl_entry1: got %h want 0020", busy_mask); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL fl_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL fl_release: got %b want 0", flush); end
    drain();
  endtask

  task automatic test_ext_stall();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);  // LW R7
    step();
    set_id(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    ext_stall = 1'b1; br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++; if (fwd_rs_sel !== 2'd1) begin n_fail++; $display("FAIL es_fwd[%0d]: got %0d want 1", i, fwd_rs_sel); end
      n_checks++; if ({stall_if_id, bubble_ex, flush} !== 3'b000) begin n_fail++; $display("FAIL es_ctrl[%0d]: got %b want 000", i, {stall_if_id, bubble_ex, flush}); end
      n_checks++; if (busy_mask !== 16'h0080) begin n_fail++; $display("FAIL es_busy[%0d]: got %h want 0080", i, busy_mask); end
      n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL es_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt); end
      step();
    end
    ext_stall = 1'b0; br_taken = 1'b0;
    settle();
    n_checks++; if (stall_if_id !== 1'b1) begin n_fail++; $display("FAIL es_resume_stall: got %b want 1", stall_if_id); end
    step();
    exp_cnt++;
    settle();
    n_checks++; if (fwd_rs_sel !== 2'd2) begin n_fail++; $display("FAIL es_resume_fwd: got %0d want 2", fwd_rs_sel); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL es_resume_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    step();
    drain();
  endtask

  task automatic test_zero_reg();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);  // LW R0
    step();
    set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0);
    settle();
    n_checks++; if (fwd_rs_sel !== 2'd0) begin n_fail++; $display("FAIL zr_rs: got %0d want 0", fwd_rs_sel); end
    n_checks++; if (fwd_rt_sel !== 2'd0) begin n_fail++; $display("FAIL zr_rt: got %0d want 0", fwd_rt_sel); end
    n_checks++; if (busy_mask !== 16'h0001) begin n_fail++; $display("FAIL zr_busy: got %h want 0001", busy_mask); end
    n_checks++; if (stall_if_id !== 1'b0) begin n_fail++; $display("FAIL zr_stall: got %b want 0", stall_if_id); end
    step();
    drain();
  endtask

  task automatic test_rt_path();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b1);  // LW R8
    step();
    set_id(1'b1, 4'd8, 1'b0, 4'd8, 1'b1, 4'd9, 1'b1, 1'b0);  // rs field unused
    settle();
    n_checks++; if (stall_if_id !== 1'b1) begin n_fail++; $display("FAIL rt_stall: got %b want 1", stall_if_id); end
    n_checks++; if (fwd_rt_sel !== 2'd0) begin n_fail++; $display("FAIL rt_fwd_zero: got %0d want 0", fwd_rt_sel); end
    step();
    exp_cnt++;
    settle();
    n_checks++; if (fwd_rt_sel !== 2'd2) begin n_fail++; $display("FAIL rt_fwd_k2: got %0d want 2", fwd_rt_sel); end
    n_checks++; if (fwd_rs_sel !== 2'd0) begin n_fail++; $display("FAIL rt_rs_unused: got %0d want 0", fwd_rs_sel); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL rt_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    step();
    drain();
  endtask

  task automatic test_async_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);  // LW R5
    step();
    set_id(1'b1, 4'd5, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1, 1'b0);
    settle();
    n_checks++; if (stall_if_id !== 1'b1) begin n_fail++; $display("FAIL ar_pre_stall: got %b want 1", stall_if_id); end
    n_checks++; if (stall_cnt === 16'h0) begin n_fail++; $display("FAIL ar_pre_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    Rst = 1'b0;
    #1;
    n_checks++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL ar_busy: got %h want 0000", busy_mask); end
    n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", stall_cnt); end
    n_checks++; if ({stall_if_id, bubble_ex, flush} !== 3'b000) begin n_fail++; $display("FAIL ar_ctrl: got %b want 000", {stall_if_id, bubble_ex, flush}); end
    n_checks++; if ({fwd_rs_sel, fwd_rt_sel} !== 4'b0) begin n_fail++; $display("FAIL ar_fwd: got %b want 0000", {fwd_rs_sel, fwd_rt_sel}); end
    step();
    idle();
    #2 Rst = 1'b1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_after_reset();
    step();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);  // ADD R3
    step();
    idle();
    settle();
    n_checks++; if (busy_mask !== 16'h0008) begin n_fail++; $display("FAIL pr_first_edge: got %h want 0008", busy_mask); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL pr_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  initial begin
    idle();
    Rst = 1'b0;
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_flush();
    test_ext_stall();
    test_zero_reg();
    test_rt_path();
    test_async_reset();
    test_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
